// File: rtl/morse_pkg.sv
// Shared Morse seminibble definitions for the player, key-input handler and encoding LUT.
package morse_pkg;

    localparam int unsigned SN_W     = 2;
    localparam int unsigned CODE_W   = 10;
    localparam int unsigned MAX_SYMS = 5;

    localparam logic [SN_W-1:0] SN_DOT  = 2'b10;
    localparam logic [SN_W-1:0] SN_DASH = 2'b11;
    localparam logic [SN_W-1:0] SN_END  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TONE,
        ST_GAP,
        ST_TAIL,
        ST_DONE
    } player_state_e;

    // True for a playable seminibble; 00 and 01 both end the letter.
    function automatic logic is_symbol(input logic [SN_W-1:0] pair);
        return (pair == SN_DOT) || (pair == SN_DASH);
    endfunction

endpackage

// File: rtl/morse_player_if.sv
// Control/keying bundle between the letter demonstrator control and the Morse player.
interface morse_player_if;

    logic                         start;
    logic [morse_pkg::CODE_W-1:0] code;
    logic                         abort;
    logic                         tone;
    logic                         sym_dash;
    logic                         busy;
    logic                         done;

    modport master (
        output start, code, abort,
        input  tone, sym_dash, busy, done
    );

    modport slave (
        input  start, code, abort,
        output tone, sym_dash, busy, done
    );

endinterface

// File: rtl/morse_unit_timer.sv
// Morse time-unit prescaler; unit_tick marks the last clk of each unit, clear restarts the unit.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic unit_tick
);

    localparam int unsigned CNT_W = $clog2(UNIT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    assign unit_tick = (r_cnt == CNT_W'(UNIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear || unit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_player.sv
// Plays a 10-bit seminibble Morse code as timed on/off keying on tone.
module morse_player
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES      = 12_500_000,
    parameter int unsigned DOT_UNITS        = 1,
    parameter int unsigned DASH_UNITS       = 3,
    parameter int unsigned SYM_GAP_UNITS    = 1,
    parameter int unsigned LETTER_GAP_UNITS = 3
) (
    input  logic           clk,
    input  logic           reset,
    morse_player_if.slave  bus
);

    localparam int unsigned UNIT_W = 3;
    localparam int unsigned SYM_W  = 3;

    player_state_e     r_state, w_state_nxt;
    logic [CODE_W-1:0] r_sh, w_sh_nxt;
    logic [UNIT_W-1:0] r_units, w_units_nxt;
    logic [SYM_W-1:0]  r_syms, w_syms_nxt;
    logic [UNIT_W-1:0] w_phase_len;
    logic [SN_W-1:0]   w_pair, w_pair_nxt;
    logic              w_unit_tick, w_timer_clear, w_phase_end;
    logic              r_tone, r_dash, r_busy, r_done;
    logic              w_tone_nxt, w_dash_nxt, w_busy_nxt, w_done_nxt;

    assign w_pair      = r_sh[CODE_W-1 -: SN_W];
    assign w_pair_nxt  = r_sh[CODE_W-SN_W-1 -: SN_W];
    assign w_phase_end = w_unit_tick && (UNIT_W'(r_units + UNIT_W'(1)) == w_phase_len);

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_timer_clear),
        .unit_tick (w_unit_tick)
    );

    always_comb begin
        w_phase_len = '0;
        unique case (r_state)
            ST_TONE: w_phase_len = (w_pair == SN_DASH) ? UNIT_W'(DASH_UNITS) : UNIT_W'(DOT_UNITS);
            ST_GAP:  w_phase_len = UNIT_W'(SYM_GAP_UNITS);
            ST_TAIL: w_phase_len = UNIT_W'(LETTER_GAP_UNITS);
            default: w_phase_len = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_units <= '0;
            r_syms  <= '0;
            r_tone  <= 1'b0;
            r_dash  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_units <= w_units_nxt;
            r_syms  <= w_syms_nxt;
            r_tone  <= w_tone_nxt;
            r_dash  <= w_dash_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_units_nxt = r_units;
        w_syms_nxt  = r_syms;

        if (w_unit_tick) begin
            w_units_nxt = r_units + UNIT_W'(1);
        end

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_sh_nxt    = bus.code;
                    w_syms_nxt  = '0;
                    w_state_nxt = is_symbol(bus.code[CODE_W-1 -: SN_W]) ? ST_TONE : ST_DONE;
                end
            end
            ST_TONE: begin
                if (w_phase_end) begin
                    w_sh_nxt    = {r_sh[CODE_W-SN_W-1:0], SN_END};
                    w_syms_nxt  = r_syms + SYM_W'(1);
                    w_state_nxt = (is_symbol(w_pair_nxt) && (w_syms_nxt < SYM_W'(MAX_SYMS)))
                                  ? ST_GAP : ST_TAIL;
                end
            end
            ST_GAP:  if (w_phase_end) w_state_nxt = ST_TONE;
            ST_TAIL: if (w_phase_end) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort overrides whatever the phase logic decided.
        if (bus.abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end

        // Every phase starts with fresh unit and prescaler counts so lengths never drift.
        if (w_state_nxt != r_state) begin
            w_units_nxt = '0;
        end
        w_timer_clear = (w_state_nxt != r_state) || (r_state == ST_IDLE);

        w_tone_nxt = (w_state_nxt == ST_TONE);
        w_dash_nxt = w_tone_nxt && (w_sh_nxt[CODE_W-1 -: SN_W] == SN_DASH);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    assign bus.tone     = r_tone;
    assign bus.sym_dash = r_dash;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player with a 4-cycle time unit.
module tb_morse_player;

    localparam int LIMIT = 200;
    localparam int INJ_NONE  = 0;
    localparam int INJ_START = 1;
    localparam int INJ_ABORT = 2;
    localparam int INJ_RESET = 3;

    localparam logic [9:0] C_E    = 10'b1000000000;
    localparam logic [9:0] C_A    = 10'b1011000000;
    localparam logic [9:0] C_ZERO = 10'b1111111111;
    localparam logic [9:0] C_NONE = 10'b0000000000;
    localparam logic [9:0] C_TERM = 10'b1001101010;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic tone_tr [0:LIMIT+1];
    logic dash_tr [0:LIMIT+1];

    morse_player_if bus ();

    morse_player #(.UNIT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_play(input logic [9:0] c);
        @(negedge clk);
        bus.start = 1'b1;
        bus.code  = c;
        next_cycle();
        bus.start = 1'b0;
    endtask

    // Observes from cycle 1 until busy drops; optional one-cycle injection at cycle inj.
    task automatic monitor(input string nm, input int inj, input int kind,
                           input int e_on, input int e_rise, input int e_dash,
                           input int e_done, input int e_busy);
        int   on, rise, dash, bad_dash, done_at, done_n, busy_n, c;
        logic prev;
        on = 0; rise = 0; dash = 0; bad_dash = 0; done_at = 0; done_n = 0; busy_n = 0;
        prev = 1'b0;
        c = 1;
        for (int i = 0; i <= LIMIT + 1; i++) begin
            tone_tr[i] = 1'b0;
            dash_tr[i] = 1'b0;
        end
        while (c <= LIMIT && bus.busy === 1'b1) begin
            tone_tr[c] = bus.tone;
            dash_tr[c] = bus.sym_dash;
            if (bus.tone) on++;
            if (bus.tone && !prev) rise++;
            prev = bus.tone;
            if (bus.sym_dash) dash++;
            if (bus.sym_dash && !bus.tone) bad_dash++;
            if (bus.done) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            busy_n++;
            bus.start = (c == inj) && (kind == INJ_START);
            bus.abort = (c == inj) && (kind == INJ_ABORT);
            reset     = !((c == inj) && (kind == INJ_RESET));
            if (bus.start) bus.code = ~C_E;
            next_cycle();
            c++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b1;
        check_eq({nm, "_ended"}, 32'(c <= LIMIT), 32'd1);
        check_eq({nm, "_on"}, 32'(on), 32'(e_on));
        check_eq({nm, "_rise"}, 32'(rise), 32'(e_rise));
        check_eq({nm, "_dash"}, 32'(dash), 32'(e_dash));
        check_eq({nm, "_dash_wo_tone"}, 32'(bad_dash), 32'd0);
        check_eq({nm, "_done_at"}, 32'(done_at), 32'(e_done));
        check_eq({nm, "_done_n"}, 32'(done_n), (e_done != 0) ? 32'd1 : 32'd0);
        check_eq({nm, "_busy_n"}, 32'(busy_n), 32'(e_busy));
        check_eq({nm, "_tone_idle"}, 32'(bus.tone), 32'd0);
        check_eq({nm, "_done_idle"}, 32'(bus.done), 32'd0);
    endtask

    task automatic run(input string nm, input logic [9:0] c, input int inj, input int kind,
                       input int e_on, input int e_rise, input int e_dash,
                       input int e_done, input int e_busy);
        start_play(c);
        monitor(nm, inj, kind, e_on, e_rise, e_dash, e_done, e_busy);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.code  = '0;
        repeat (3) next_cycle();
        check_eq("rst_tone", 32'(bus.tone), 32'd0);
        check_eq("rst_dash", 32'(bus.sym_dash), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        repeat (2) next_cycle();

        run("e", C_E, 0, INJ_NONE, 4, 1, 0, 17, 17);
        check_eq("e_t4", 32'(tone_tr[4]), 32'd1);
        check_eq("e_t5", 32'(tone_tr[5]), 32'd0);

        run("a", C_A, 0, INJ_NONE, 16, 2, 12, 33, 33);
        check_eq("a_t8", 32'(tone_tr[8]), 32'd0);
        check_eq("a_t9", 32'(tone_tr[9]), 32'd1);
        check_eq("a_d9", 32'(dash_tr[9]), 32'd1);
        check_eq("a_d4", 32'(dash_tr[4]), 32'd0);
        check_eq("a_t20", 32'(tone_tr[20]), 32'd1);
        check_eq("a_t21", 32'(tone_tr[21]), 32'd0);

        run("zero", C_ZERO, 0, INJ_NONE, 60, 5, 60, 89, 89);
        check_eq("zero_t76", 32'(tone_tr[76]), 32'd1);
        check_eq("zero_t77", 32'(tone_tr[77]), 32'd0);

        run("empty", C_NONE, 0, INJ_NONE, 0, 0, 0, 1, 1);
        run("term", C_TERM, 0, INJ_NONE, 4, 1, 0, 17, 17);
        run("e_start6", C_E, 6, INJ_START, 4, 1, 0, 17, 17);
        run("e_start_done", C_E, 17, INJ_START, 4, 1, 0, 17, 17);
        next_cycle();
        check_eq("e_start_done_idle", 32'(bus.busy), 32'd0);

        // Abort during the dash, then a fresh start in cycle 12.
        run("a_abort10", C_A, 10, INJ_ABORT, 6, 2, 2, 0, 10);
        next_cycle();
        check_eq("abort_c12_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.code  = C_E;
        next_cycle();
        bus.start = 1'b0;
        check_eq("restart_c13_tone", 32'(bus.tone), 32'd1);
        monitor("restart_e", 0, INJ_NONE, 4, 1, 0, 17, 17);

        // Abort together with start in IDLE must not launch playback.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.code  = C_A;
        next_cycle();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("idle_abort_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_abort_tone", 32'(bus.tone), 32'd0);
        next_cycle();

        run("a_reset7", C_A, 7, INJ_RESET, 4, 1, 0, 0, 7);
        check_eq("a_reset7_dash_out", 32'(bus.sym_dash), 32'd0);
        run("a_replay", C_A, 0, INJ_NONE, 16, 2, 12, 33, 33);
        check_eq("a_replay_t9", 32'(tone_tr[9]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
